// File: rtl/panic_rx_checker_pkg.sv
// Shared constants for the PANIC receive-side checker: error flag bit indices,
// header byte offsets, FSM state encoding and the expected IP length helper.
package panic_rx_checker_pkg;

  localparam int ERR_KEEP    = 0;
  localparam int ERR_PAYLOAD = 1;
  localparam int ERR_LENGTH  = 2;
  localparam int ERR_SEQ     = 3;
  localparam int ERR_REORDER = 4;
  localparam int ERR_BITS    = 5;

  localparam int HDR_OFS_IPLEN_HI = 16;
  localparam int HDR_OFS_IPLEN_LO = 17;
  localparam int HDR_OFS_FLOW     = 35;

  localparam logic [15:0] ETH_HDR_BYTES = 16'd14;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_BASE    = 2'd1,
    ST_PAYLOAD = 2'd2
  } rx_state_e;

  // IP length implied by a frame whose last beat has index last_idx (16-bit wrap).
  function automatic logic [15:0] expected_iplen(input logic [15:0] last_idx);
    logic [15:0] beats;
    beats = last_idx + 16'd1;
    return (beats * 16'd64) - ETH_HDR_BYTES;
  endfunction

endpackage

// File: rtl/panic_rx_checker_flow_tracker.sv
// Per-flow tracker: remembers the last sequence number seen for one flow,
// flags out-of-order/duplicate frames and counts the flow's packets.
module panic_rx_flow_tracker #(
  parameter int CNT_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 fin,
  input  logic [8:0]           seq9,
  output logic                 reorder,
  output logic [CNT_WIDTH-1:0] pkts
);

  logic [8:0]           last_seq9_r;
  logic                 valid_r;
  logic [CNT_WIDTH-1:0] pkts_r;
  logic [8:0]           diff_s;

  // A frame is out of order when it does not advance by 1..255 modulo 512.
  always_comb begin
    diff_s  = seq9 - last_seq9_r;
    reorder = valid_r && ((diff_s == 9'd0) || diff_s[8]);
  end

  // Last-sequence history and flow packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_seq9_r <= 9'd0;
      valid_r     <= 1'b0;
      pkts_r      <= {CNT_WIDTH{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
      pkts_r  <= {CNT_WIDTH{1'b0}};
    end else if (fin) begin
      last_seq9_r <= seq9;
      valid_r     <= 1'b1;
      pkts_r      <= pkts_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign pkts = pkts_r;

endmodule

// File: rtl/panic_rx_checker.sv
// AXI-Stream sink for PANIC's DMA-facing output: parses header/base/payload beats,
// checks the generator's pattern and keeps packet, byte, flow and error statistics.
module panic_rx_checker
  import panic_rx_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int FLOW_A_ID  = 33,
  parameter int FLOW_B_ID  = 44,
  parameter int CNT_WIDTH  = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  stat_clear,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  byte_count,
  output logic [CNT_WIDTH-1:0]  flow_a_pkts,
  output logic [CNT_WIDTH-1:0]  flow_b_pkts,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ERR_BITS-1:0]   err_status
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_BEAT = CNT_WIDTH'(64);

  rx_state_e             state_r, state_nxt_s;
  logic                  tready_r;
  logic [8:0]            seq9_r;
  logic [7:0]            flow_r;
  logic [15:0]           iplen_r, idx_r;
  logic [63:0]           base_r;
  logic [ERR_BITS-1:0]   frame_err_r;
  logic [CNT_WIDTH-1:0]  pkt_count_r, byte_count_r, err_count_r;
  logic [ERR_BITS-1:0]   err_status_r;

  logic                  acc_s, fin_s;
  logic [8:0]            cur_seq9_s;
  logic [7:0]            cur_flow_s;
  logic [15:0]           cur_iplen_s, idx_last_s;
  logic [63:0]           base_s;
  logic [ERR_BITS-1:0]   beat_flags_s, acc_flags_s, fin_flags_s;
  logic                  match_a_s, match_b_s, reorder_a_s, reorder_b_s;

  assign acc_s     = s_axis_tvalid & tready_r;
  assign fin_s     = acc_s & s_axis_tlast;
  assign base_s    = s_axis_tdata[63:0] - 64'd1;
  assign match_a_s = (cur_flow_s == 8'(FLOW_A_ID));
  assign match_b_s = (cur_flow_s == 8'(FLOW_B_ID));

  // Next state plus per-beat and per-frame error flags; header fields bypass on the header beat.
  always_comb begin
    state_nxt_s  = state_r;
    cur_seq9_s   = seq9_r;
    cur_flow_s   = flow_r;
    cur_iplen_s  = iplen_r;
    idx_last_s   = idx_r;
    beat_flags_s = {ERR_BITS{1'b0}};
    case (state_r)
      ST_HDR: begin
        cur_seq9_s  = s_axis_tdata[8:0];
        cur_flow_s  = s_axis_tdata[HDR_OFS_FLOW*8 +: 8];
        cur_iplen_s = {s_axis_tdata[HDR_OFS_IPLEN_HI*8 +: 8], s_axis_tdata[HDR_OFS_IPLEN_LO*8 +: 8]};
        idx_last_s  = 16'd0;
        state_nxt_s = (acc_s && !s_axis_tlast) ? ST_BASE : ST_HDR;
      end
      ST_BASE: begin
        beat_flags_s[ERR_SEQ] = (base_s[8:0] != seq9_r);
        if (acc_s) begin
          state_nxt_s = s_axis_tlast ? ST_HDR : ST_PAYLOAD;
        end else begin
          state_nxt_s = ST_BASE;
        end
      end
      ST_PAYLOAD: begin
        beat_flags_s[ERR_PAYLOAD] = (s_axis_tdata[63:0] != (base_r + {48'd0, idx_r}));
        state_nxt_s = fin_s ? ST_HDR : ST_PAYLOAD;
      end
      default: state_nxt_s = ST_HDR;
    endcase
    beat_flags_s[ERR_KEEP]   = (s_axis_tkeep != {KEEP_WIDTH{1'b1}});
    acc_flags_s              = frame_err_r | beat_flags_s;
    fin_flags_s              = acc_flags_s;
    fin_flags_s[ERR_LENGTH]  = (expected_iplen(idx_last_s) != cur_iplen_s);
    fin_flags_s[ERR_REORDER] = (match_a_s & reorder_a_s) | (match_b_s & reorder_b_s);
  end

  // Frame parsing state; untouched by stat_clear so an in-flight frame keeps its flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_HDR;
      tready_r    <= 1'b0;
      seq9_r      <= 9'd0;
      flow_r      <= 8'd0;
      iplen_r     <= 16'd0;
      idx_r       <= 16'd0;
      base_r      <= 64'd0;
      frame_err_r <= {ERR_BITS{1'b0}};
    end else begin
      tready_r <= 1'b1;
      state_r  <= state_nxt_s;
      if (acc_s) begin
        frame_err_r <= fin_s ? {ERR_BITS{1'b0}} : acc_flags_s;
        case (state_r)
          ST_HDR: begin
            seq9_r  <= cur_seq9_s;
            flow_r  <= cur_flow_s;
            iplen_r <= cur_iplen_s;
            idx_r   <= 16'd1;
          end
          ST_BASE: begin
            base_r <= base_s;
            idx_r  <= 16'd2;
          end
          ST_PAYLOAD: idx_r <= idx_r + 16'd1;
          default:    idx_r <= 16'd0;
        endcase
      end
    end
  end

  // Global statistics; a clear in the same cycle as a finalize drops that frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_r  <= {CNT_WIDTH{1'b0}};
      byte_count_r <= {CNT_WIDTH{1'b0}};
      err_count_r  <= {CNT_WIDTH{1'b0}};
      err_status_r <= {ERR_BITS{1'b0}};
    end else if (stat_clear) begin
      pkt_count_r  <= {CNT_WIDTH{1'b0}};
      byte_count_r <= {CNT_WIDTH{1'b0}};
      err_count_r  <= {CNT_WIDTH{1'b0}};
      err_status_r <= {ERR_BITS{1'b0}};
    end else begin
      if (acc_s) begin
        byte_count_r <= byte_count_r + CNT_BEAT;
      end
      if (fin_s) begin
        pkt_count_r <= pkt_count_r + CNT_ONE;
        if (|fin_flags_s) begin
          err_count_r  <= err_count_r + CNT_ONE;
          err_status_r <= err_status_r | fin_flags_s;
        end
      end
    end
  end

  panic_rx_flow_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_flow_a (
    .clk     (clk),
    .rst     (rst),
    .clear   (stat_clear),
    .fin     (fin_s & match_a_s),
    .seq9    (cur_seq9_s),
    .reorder (reorder_a_s),
    .pkts    (flow_a_pkts)
  );

  panic_rx_flow_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_flow_b (
    .clk     (clk),
    .rst     (rst),
    .clear   (stat_clear),
    .fin     (fin_s & match_b_s),
    .seq9    (cur_seq9_s),
    .reorder (reorder_b_s),
    .pkts    (flow_b_pkts)
  );

  assign s_axis_tready = tready_r;
  assign pkt_count     = pkt_count_r;
  assign byte_count    = byte_count_r;
  assign err_count     = err_count_r;
  assign err_status    = err_status_r;

endmodule

// File: doc/panic_rx_checker.md
# panic_rx_checker

Synthesizable AXI-Stream sink on PANIC's `m_rx_axis` output (the DMA-facing side), the receive end of the packet generator's stream. Parses each frame, verifies header fields and the generator's incrementing payload pattern, and keeps packet, byte, per-flow and error statistics. Runs on hardware in place of the DMA for throughput and integrity tests.

## Interface
Parameters:
- `DATA_WIDTH`, 512: stream width; only 512 is supported.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `FLOW_A_ID`, 33: flow byte value counted in `flow_a_pkts`.
- `FLOW_B_ID`, 44: flow byte value counted in `flow_b_pkts`.
- `CNT_WIDTH`, 48: statistics counter width.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-low reset. Low asserts; release is synchronous to `clk`.
- `s_axis_tdata` in 512: frame data.
- `s_axis_tkeep` in 64: byte enables.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` out 1: sink ready.
- `s_axis_tlast` in 1: last beat of frame.
- `stat_clear` in 1: synchronous clear of all counters and sticky errors.
- `pkt_count` out CNT_WIDTH: frames completed.
- `byte_count` out CNT_WIDTH: accepted beats × 64.
- `flow_a_pkts`, `flow_b_pkts` out CNT_WIDTH: frames per matching flow.
- `err_count` out CNT_WIDTH: frames with one or more errors.
- `err_status` out 5: sticky flags. [0] keep, [1] payload, [2] length, [3] seq, [4] reorder.

## Operation
- A beat is accepted when `s_axis_tvalid && s_axis_tready`. `s_axis_tready` is 1 whenever reset is deasserted.
- FSM states:
  - `HDR`: the accepted beat is a header. Capture `seq9 = tdata[8:0]`, `flow = tdata[35*8 +: 8]`, and `iplen = {tdata[16*8 +: 8], tdata[17*8 +: 8]}`. Set beat index to 1. If tlast, finalize the frame and stay in HDR; otherwise go to BASE.
  - `BASE`: lock `base = tdata[63:0] - 1`. Flag seq if `base[8:0] != seq9`. Index becomes 2. Go to PAYLOAD, or finalize and return to HDR on tlast.
  - `PAYLOAD`: flag payload if `tdata[63:0] != base + idx`. Increment idx. On tlast, finalize and return to HDR.
- Every accepted beat: flag keep if `tkeep != all-ones`.
- Finalize, on the tlast beat:
  - Flag length if `(idx_at_last + 1) * 64 - 14 != iplen`, computed in 16 bits with wrap.
  - Reorder check, per flow A/B only: keep `last_seq9` and a valid bit. Flag reorder if valid and `(seq9 - last_seq9) mod 512` is 0 or ≥ 256. Then update `last_seq9`.
  - Increment `pkt_count`, plus the matching flow counter. Frames whose flow matches neither ID count only in `pkt_count`.
  - If any flag is set for this frame, increment `err_count` once and OR the frame's flags into `err_status`.
- Counters wrap at 2^CNT_WIDTH silently.
- `stat_clear` zeroes counters, `err_status` and the last_seq valid bits. It does not affect the FSM or the in-flight frame's local flags.
- If `stat_clear` and a finalize occur in the same cycle, the clear wins and the frame is not counted.

## Timing
- All outputs are registered and update the cycle after the accepting edge. Statistics lag tlast by 1 cycle.
- Reset values: every counter 0, `err_status` 0, FSM in `HDR`, `s_axis_tready` 0, last_seq valid bits 0.
- No back-pressure, so throughput is one beat per cycle.
- Gaps (tvalid low) mid-frame hold all state.
- Reset asserted mid-frame discards the frame and clears everything asynchronously. The first beat after release is treated as a header.

## Structure
- Use the shared `panic_define.v` macros: add `PANIC_CHK_ERR_*` bit indices and the header byte offsets (16, 17, 35).
- Optional sub-module `panic_rx_flow_tracker`, instantiated twice: holds last_seq9 and the valid bit, performs the reorder compare and counts flow packets.
- Main FSM and arithmetic live in the top module.

## Test plan
- Single-beat frame: header seq 5, flow 33, iplen 50, tlast → pkt_count 1, flow_a_pkts 1, err_count 0, byte_count 64.
- 4-beat frame: header seq 7; payloads 7+1, 7+2, 7+3; iplen 242 → no errors, byte_count 256.
- Payload beat 2 corrupted to 0xDEAD → err_status[1] set, err_count 1, pkt_count 1.
- Flow 44 frames in seq order 10, 12, 11 → third frame sets err_status[4]. Seq 511 followed by 0 does not set it.
- tkeep 0x0F on the last beat, plus iplen 100 on a 2-beat frame → err_status[0] and [2] set, err_count 1.
- Reset asserted low after beat 2 of a 4-beat frame, then a fresh 1-beat frame → counters reflect only the new frame. Also: `stat_clear` in the same cycle as a finalize → pkt_count stays 0.
